// File: rtl/age_issue_buf.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : age_issue_buf
// Description : Age-ordered issue buffer. Picks the oldest valid+ready entry
//               for a valid/ready issue port.
// Revision    : 1.0 - initial release
// ============================================================================
module age_issue_buf #(
    parameter int WIDTH  = 4,
    parameter int DATA_W = 8,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       alloc_vld,
    output logic                       alloc_rdy,
    input  logic [DATA_W-1:0]          alloc_data,
    input  logic                       alloc_ready,
    input  logic [WIDTH-1:0]           wake_vec,
    output logic                       iss_vld,
    input  logic                       iss_rdy,
    output logic [DATA_W-1:0]          iss_data,
    output logic [IDX_W-1:0]           iss_idx,
    output logic [$clog2(WIDTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]                r_valid;
    logic [WIDTH-1:0]                r_ready;
    logic [WIDTH-1:0][DATA_W-1:0]    r_data;
    logic [WIDTH-1:0][WIDTH-1:0]     r_age;
    logic [OCC_W-1:0]                r_occupancy;

    logic [WIDTH-1:0]                w_cand;
    logic [WIDTH-1:0]                w_sel;
    logic [WIDTH-1:0]                w_alloc_oh;
    logic [WIDTH-1:0]                w_alloc_set;
    logic [WIDTH-1:0]                w_issue_clr;
    logic [WIDTH-1:0]                w_valid_nxt;
    logic [WIDTH-1:0]                w_ready_nxt;
    logic [WIDTH-1:0][WIDTH-1:0]     w_age_nxt;
    logic [OCC_W-1:0]                w_occ_nxt;
    logic [DATA_W-1:0]               w_iss_data;
    logic [IDX_W-1:0]                w_iss_idx;
    logic                            w_alloc_fire;
    logic                            w_issue_fire;

    assign w_cand = r_valid & r_ready;

    // Slot i wins when it is older than every other candidate.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sel
            assign w_sel[gi] = w_cand[gi] &&
                ((w_cand & ~r_age[gi] & ~(WIDTH'(1) << gi)) == '0);
        end
    endgenerate

    always_comb begin
        w_iss_data = '0;
        w_iss_idx  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (w_sel[i]) begin
                w_iss_data = w_iss_data | r_data[i];
                w_iss_idx  = w_iss_idx | IDX_W'(i);
            end
        end
    end

    assign iss_vld   = |w_cand;
    assign iss_data  = w_iss_data;
    assign iss_idx   = w_iss_idx;
    assign alloc_rdy = ~&r_valid;
    assign occupancy = r_occupancy;

    // Lowest clear bit of r_valid as a one-hot (zero when full).
    assign w_alloc_oh   = ~r_valid & (r_valid + WIDTH'(1));
    assign w_alloc_fire = alloc_vld & alloc_rdy;
    assign w_issue_fire = iss_vld & iss_rdy;
    assign w_alloc_set  = w_alloc_fire ? w_alloc_oh : '0;
    assign w_issue_clr  = w_issue_fire ? w_sel : '0;

    assign w_valid_nxt = (r_valid & ~w_issue_clr) | w_alloc_set;
    assign w_ready_nxt = ((r_ready | (wake_vec & r_valid)) & ~w_issue_clr & ~w_alloc_set)
                       | (w_alloc_set & {WIDTH{alloc_ready}});

    // New entry becomes younger than everything currently valid.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                w_age_nxt[i][j] = r_age[i][j];
                if (w_alloc_set[i]) w_age_nxt[i][j] = 1'b0;
                if (w_alloc_set[j]) w_age_nxt[i][j] = r_valid[i];
            end
        end
    end

    always_comb begin
        w_occ_nxt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_occ_nxt = w_occ_nxt + OCC_W'(w_valid_nxt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid     <= '0;
            r_ready     <= '0;
            r_data      <= '0;
            r_age       <= '0;
            r_occupancy <= '0;
        end else if (flush) begin
            r_valid     <= '0;
            r_ready     <= '0;
            r_occupancy <= '0;
        end else begin
            r_valid     <= w_valid_nxt;
            r_ready     <= w_ready_nxt;
            r_age       <= w_age_nxt;
            r_occupancy <= w_occ_nxt;
            for (int k = 0; k < WIDTH; k++) begin
                if (w_alloc_set[k]) r_data[k] <= alloc_data;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_inv_row
            for (genvar gj = gi + 1; gj < WIDTH; gj++) begin : g_inv_col
                a_age_antisym : assert property (@(posedge clk) disable iff (!rst_n)
                    (r_valid[gi] && r_valid[gj]) |-> (r_age[gi][gj] != r_age[gj][gi]));
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_age_issue_buf.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_age_issue_buf
// Description : Directed + random bench for age_issue_buf against a
//               timestamp-ordered reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_age_issue_buf;

    localparam int W  = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n, flush, alloc_vld, alloc_ready, iss_rdy;
    logic [DW-1:0] alloc_data;
    logic [W-1:0]  wake_vec;
    logic          alloc_rdy, iss_vld;
    logic [DW-1:0] iss_data;
    logic [1:0]    iss_idx;
    logic [2:0]    occupancy;

    int errors = 0;
    int checks = 0;

    // Reference model: each entry carries an allocation timestamp; oldest = smallest.
    bit            m_valid [W];
    bit            m_ready [W];
    logic [DW-1:0] m_data  [W];
    int            m_stamp [W];
    int            stamp_ctr = 0;

    logic [DW-1:0] exp_d [4];
    int            exp_i [4];

    age_issue_buf #(.WIDTH(W), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .alloc_vld(alloc_vld), .alloc_rdy(alloc_rdy), .alloc_data(alloc_data),
        .alloc_ready(alloc_ready), .wake_vec(wake_vec),
        .iss_vld(iss_vld), .iss_rdy(iss_rdy), .iss_data(iss_data),
        .iss_idx(iss_idx), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    function automatic int exp_sel();
        int best = -1;
        for (int i = 0; i < W; i++)
            if (m_valid[i] && m_ready[i] && (best < 0 || m_stamp[i] < m_stamp[best]))
                best = i;
        return best;
    endfunction

    function automatic int count_valid();
        int n = 0;
        for (int i = 0; i < W; i++) n += int'(m_valid[i]);
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int s = exp_sel();
        chk("alloc_rdy", {31'd0, alloc_rdy}, (count_valid() < W) ? 32'd1 : 32'd0);
        chk("iss_vld", {31'd0, iss_vld}, (s >= 0) ? 32'd1 : 32'd0);
        chk("iss_idx", {30'd0, iss_idx}, (s >= 0) ? s : 0);
        chk("iss_data", {24'd0, iss_data}, (s >= 0) ? {24'd0, m_data[s]} : 32'd0);
        chk("occupancy", {29'd0, occupancy}, count_valid());
    endtask

    task automatic model_update();
        int s = exp_sel();
        int k = -1;
        if (!rst_n) begin
            for (int i = 0; i < W; i++) begin
                m_valid[i] = 0; m_ready[i] = 0; m_data[i] = '0;
            end
        end else if (flush) begin
            for (int i = 0; i < W; i++) begin
                m_valid[i] = 0; m_ready[i] = 0;
            end
        end else begin
            for (int i = 0; i < W; i++)
                if (k < 0 && !m_valid[i]) k = i;
            for (int i = 0; i < W; i++)
                if (m_valid[i] && wake_vec[i]) m_ready[i] = 1;
            if (s >= 0 && iss_rdy) begin
                m_valid[s] = 0; m_ready[s] = 0;
            end
            if (alloc_vld && k >= 0) begin
                m_valid[k] = 1;
                m_ready[k] = alloc_ready;
                m_data[k]  = alloc_data;
                m_stamp[k] = stamp_ctr;
                stamp_ctr++;
            end
        end
    endtask

    task automatic tick();
        check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        rst_n = 1; flush = 0; alloc_vld = 0; alloc_data = '0;
        alloc_ready = 0; wake_vec = '0; iss_rdy = 0;
    endtask

    task automatic alloc_one(input logic [DW-1:0] d, input logic rdy);
        alloc_vld = 1; alloc_data = d; alloc_ready = rdy;
        tick();
        alloc_vld = 0;
    endtask

    initial begin
        idle();
        rst_n = 0;
        @(negedge clk);
        @(posedge clk);
        model_update();
        @(negedge clk);
        idle();

        chk("rst_alloc_rdy", {31'd0, alloc_rdy}, 1);
        chk("rst_iss_vld", {31'd0, iss_vld}, 0);
        chk("rst_iss_data", {24'd0, iss_data}, 0);
        chk("rst_iss_idx", {30'd0, iss_idx}, 0);
        chk("rst_occ", {29'd0, occupancy}, 0);

        // In-order fill then drain
        for (int i = 0; i < 4; i++) alloc_one(8'hA0 + 8'(i), 1'b1);
        chk("s1_occ_full", {29'd0, occupancy}, 4);
        chk("s1_alloc_rdy_full", {31'd0, alloc_rdy}, 0);
        iss_rdy = 1;
        for (int i = 0; i < 4; i++) begin
            chk("s1_idx", {30'd0, iss_idx}, i);
            chk("s1_data", {24'd0, iss_data}, 32'hA0 + i);
            tick();
        end
        idle();
        chk("s1_occ_empty", {29'd0, occupancy}, 0);
        chk("s1_vld_empty", {31'd0, iss_vld}, 0);

        // Reallocated low slot is youngest
        for (int i = 0; i < 4; i++) alloc_one(8'hA0 + 8'(i), 1'b1);
        iss_rdy = 1; tick(); iss_rdy = 0;
        alloc_one(8'hB0, 1'b1);
        exp_d[0] = 8'hA1; exp_d[1] = 8'hA2; exp_d[2] = 8'hA3; exp_d[3] = 8'hB0;
        exp_i[0] = 1;     exp_i[1] = 2;     exp_i[2] = 3;     exp_i[3] = 0;
        iss_rdy = 1;
        for (int i = 0; i < 4; i++) begin
            chk("s2_idx", {30'd0, iss_idx}, exp_i[i]);
            chk("s2_data", {24'd0, iss_data}, {24'd0, exp_d[i]});
            tick();
        end
        idle();

        // Wakeup ordering
        for (int i = 0; i < 4; i++) alloc_one(8'hC0 + 8'(i), 1'b0);
        chk("s3_not_ready", {31'd0, iss_vld}, 0);
        wake_vec = 4'b1010; tick(); wake_vec = '0;
        chk("s3_vld_after_wake", {31'd0, iss_vld}, 1);
        chk("s3_idx_wake1", {30'd0, iss_idx}, 1);
        wake_vec = 4'b0001; tick(); wake_vec = '0;
        chk("s3_idx_wake0", {30'd0, iss_idx}, 0);
        wake_vec = 4'b1111; iss_rdy = 1;
        for (int i = 0; i < 5; i++) tick();
        idle();
        chk("s3_drained", {29'd0, occupancy}, 0);

        // Full buffer with concurrent alloc/issue
        for (int i = 0; i < 4; i++) alloc_one(8'hD0 + 8'(i), 1'b1);
        alloc_vld = 1; alloc_data = 8'hE0; alloc_ready = 1; iss_rdy = 1;
        chk("s4_full_no_alloc", {31'd0, alloc_rdy}, 0);
        tick();
        chk("s4_occ_after_issue", {29'd0, occupancy}, 3);
        for (int i = 1; i < 4; i++) begin
            alloc_data = 8'hE0 + 8'(i);
            tick();
            chk("s4_occ_steady", {29'd0, occupancy}, 3);
        end
        idle(); iss_rdy = 1;
        for (int i = 0; i < 4; i++) tick();
        idle();

        // Flush overrides alloc and issue
        for (int i = 0; i < 3; i++) alloc_one(8'h50 + 8'(i), 1'b1);
        chk("s5_occ3", {29'd0, occupancy}, 3);
        flush = 1; alloc_vld = 1; alloc_data = 8'h5F; iss_rdy = 1;
        tick();
        idle();
        chk("s5_occ", {29'd0, occupancy}, 0);
        chk("s5_vld", {31'd0, iss_vld}, 0);
        chk("s5_alloc_rdy", {31'd0, alloc_rdy}, 1);

        // Mid-stream reset
        alloc_one(8'h61, 1'b1);
        alloc_one(8'h62, 1'b1);
        rst_n = 0; alloc_vld = 1; alloc_data = 8'h6F; iss_rdy = 1;
        tick();
        idle();
        chk("s6_vld", {31'd0, iss_vld}, 0);
        chk("s6_occ", {29'd0, occupancy}, 0);
        chk("s6_alloc_rdy", {31'd0, alloc_rdy}, 1);
        chk("s6_data", {24'd0, iss_data}, 0);
        alloc_one(8'h70, 1'b1);
        chk("s6_realloc_idx", {30'd0, iss_idx}, 0);
        chk("s6_realloc_data", {24'd0, iss_data}, 32'h70);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            rst_n       = ($urandom_range(0, 99) != 0);
            flush       = ($urandom_range(0, 39) == 0);
            alloc_vld   = ($urandom_range(0, 2) != 0);
            alloc_data  = DW'($urandom);
            alloc_ready = 1'($urandom_range(0, 1));
            wake_vec    = ($urandom_range(0, 2) == 0) ? W'($urandom) : '0;
            iss_rdy     = ($urandom_range(0, 3) != 0);
            tick();
        end
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/age_issue_buf.md
Name: age_issue_buf

Overview:
- Age-ordered issue buffer: the consumer end of the age-matrix allocate/arbitrate path.
- Upstream allocates payload entries into free slots; per-entry ready bits are set at allocation or by a wakeup vector.
- Each cycle the block presents the oldest ready entry on a valid/ready issue port and frees that slot on handshake.
- Holds its own age matrix internally; sits between a dispatch stage and an execution/consumer stage.

Parameters:
- WIDTH, 4, number of entries/slots (>=2).
- DATA_W, 8, payload width per entry.
- IDX_W, $clog2(WIDTH), slot index width (derived, not overridden).

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset; sampled on rising edge of clk.
- flush  input  1  synchronous clear of all entries.
- alloc_vld  input  1  allocation request.
- alloc_rdy  output  1  at least one free slot.
- alloc_data  input  DATA_W  payload to store.
- alloc_ready  input  1  initial ready bit of the new entry.
- wake_vec  input  WIDTH  per-slot wakeup; sets the ready bit of valid slots.
- iss_vld  output  1  an eligible (valid and ready) entry exists.
- iss_rdy  input  1  consumer accepts.
- iss_data  output  DATA_W  payload of the selected entry.
- iss_idx  output  IDX_W  slot index of the selected entry.
- occupancy  output  $clog2(WIDTH+1)  count of valid entries.

Behaviour:
- Reset (rst_n=0 at posedge): all valid, ready and age-matrix bits cleared.
  - After reset: alloc_rdy=1, iss_vld=0, iss_data=0, iss_idx=0, occupancy=0.
  - Reset overrides flush, alloc, wake and issue.
- State per slot: valid bit, ready bit, DATA_W payload.
- Age matrix: age[i][j]=1 means slot i is older than slot j. Only bits between two valid slots are meaningful.
- Allocation:
  - Fires when alloc_vld && alloc_rdy.
  - Target slot is the lowest-index free slot in the current (pre-edge) state.
  - At the edge, the target slot gets valid=1, ready=alloc_ready and the payload.
  - The target row is cleared (age[k][*]=0) and the target column is set (age[i][k]=1 for every currently valid i).
  - A slot freed by an issue in the same cycle is not reusable until the next cycle.
  - alloc_rdy = ~&valid, combinational from registered state.
- Wakeup:
  - wake_vec[i] sets ready[i] at the edge only if valid[i] is currently 1.
  - Bits for invalid slots, including the slot being allocated this cycle, are ignored.
  - Ready is sticky until the slot is freed.
- Selection:
  - Combinational from registered state.
  - Candidates c = valid & ready.
  - Selected slot i satisfies c[i] && for all j!=i with c[j], age[i][j]=1. It is unique when c is non-zero.
  - iss_vld = |c.
  - iss_data and iss_idx come from the selected slot, and are 0 when iss_vld=0.
- Latency:
  - An entry allocated or woken at edge N is eligible from cycle N+1; there is no same-cycle bypass.
  - Minimum alloc-to-issue time is 1 cycle.
- Issue handshake:
  - iss_vld && iss_rdy frees the selected slot at the edge: valid=0, ready=0.
  - Selection is recomputed every cycle. While iss_rdy=0, iss_idx/iss_data may change if an older entry becomes ready; the consumer must not assume stability.
- Simultaneous events:
  - Alloc and issue in the same cycle: both take effect; occupancy is unchanged.
  - Full buffer: alloc_rdy=0 even if issue fires that cycle.
  - Wake and issue of the same slot in the same cycle: the issue wins and the slot becomes free.
- Flush:
  - At the edge, clears all valid and ready bits.
  - Overrides alloc, wake and issue in that cycle; iss_rdy is ignored.
  - Outputs are at reset values in the next cycle.
- occupancy: registered popcount of valid, updated at the same edge as valid.
- Invariant (checked by assertion): for valid i!=j, exactly one of age[i][j] and age[j][i] is 1.

Test Plan:
- Reset, then allocate payloads 0xA0, 0xA1, 0xA2, 0xA3 on 4 consecutive cycles with alloc_ready=1 and iss_rdy=0 -> slots 0..3, occupancy=4, alloc_rdy=0. Then iss_rdy=1 -> iss_data sequence A0, A1, A2, A3 on iss_idx 0..3; occupancy=0 and iss_vld=0 afterwards.
- Fill 4 ready entries, issue slot 0, allocate 0xB0 -> lands in slot 0 but is youngest; issue order is A1, A2, A3, B0.
- Allocate 4 entries with alloc_ready=0 -> iss_vld=0. Pulse wake_vec=4'b1010 -> next cycle iss_idx=1. Keep iss_rdy=0 and wake slot 0 -> following cycle iss_idx=0 (older entry takes over).
- Full buffer with iss_rdy=1 and alloc_vld=1 -> no allocation while full (alloc_rdy=0). Next cycle, allocation into the freed slot and an issue fire together -> occupancy stays at 3 thereafter.
- With 3 entries valid, assert flush together with alloc_vld and iss_rdy -> next cycle occupancy=0, iss_vld=0, alloc_rdy=1, no issue handshake counted.
- Assert rst_n=0 for one cycle mid-stream with 2 entries ready -> next cycle all outputs at reset values; a subsequent allocation goes to slot 0.
